// File: rtl/memory_stage.sv
// Y86-64 memory stage: byte-addressed data memory, m_stat/m_valM, and the W pipeline register.
// Optional macro DMEM_ALIGN_CHECK_EN: treat non-8-byte-aligned accesses as address errors.
module memory_stage #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:3]  M_stat,
  input  logic [3:0]  M_icode,
  input  logic        M_cnd,
  input  logic [63:0] M_valE,
  input  logic [63:0] M_valA,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  input  logic        W_stall,
  input  logic        W_bubble,
  output logic [0:3]  m_stat,
  output logic [63:0] m_valM,
  output logic [0:3]  W_stat,
  output logic [3:0]  W_icode,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM
);
  localparam int         AW    = $clog2(MEM_BYTES);
  localparam logic [0:3] S_AOK = 4'b1000;
  localparam logic [0:3] S_ADR = 4'b0010;
  localparam logic [3:0] R_NONE = 4'hF;
  localparam logic [3:0] I_NOP  = 4'h1;

  logic [7:0]    mem [MEM_BYTES];
  logic [63:0]   addr;
  logic          rd_en, wr_en, align_err, dmem_error, mem_we;
  logic [AW-1:0] base;
  logic          unused_cnd;

  assign unused_cnd = M_cnd;

  always_comb begin
    addr  = '0;
    rd_en = 1'b0;
    wr_en = 1'b0;
    case (M_icode)
      4'h4, 4'h8, 4'hA: begin addr = M_valE; wr_en = 1'b1; end
      4'h5:             begin addr = M_valE; rd_en = 1'b1; end
      4'h9, 4'hB:       begin addr = M_valA; rd_en = 1'b1; end
      default: ;
    endcase
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign align_err = (addr[2:0] != 3'b000);
`else
  assign align_err = 1'b0;
`endif

  // Unsigned compare against the last legal base so wrap-around addresses also fault.
  assign dmem_error = (rd_en || wr_en) && ((addr > 64'(MEM_BYTES - 8)) || align_err);
  assign m_stat     = dmem_error ? S_ADR : M_stat;
  assign base       = addr[AW-1:0];

  always_comb begin
    m_valM = '0;
    if (rd_en && !dmem_error)
      for (int i = 0; i < 8; i++) m_valM[8*i +: 8] = mem[base + AW'(i)];
  end

  // Any exception already at M or W kills the store; reset also blocks it.
  assign mem_we = rst_n && wr_en && !dmem_error && (M_stat == S_AOK) && (W_stat == S_AOK);

  always_ff @(posedge clk) begin
    if (mem_we)
      for (int i = 0; i < 8; i++) mem[base + AW'(i)] <= M_valA[8*i +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      W_stat  <= S_AOK;
      W_icode <= I_NOP;
      W_valE  <= '0;
      W_valM  <= '0;
      W_dstE  <= R_NONE;
      W_dstM  <= R_NONE;
    end else if (W_stall) begin
      W_stat  <= W_stat;
    end else if (W_bubble) begin
      W_stat  <= S_AOK;
      W_icode <= I_NOP;
      W_valE  <= '0;
      W_valM  <= '0;
      W_dstE  <= R_NONE;
      W_dstM  <= R_NONE;
    end else begin
      W_stat  <= m_stat;
      W_icode <= M_icode;
      W_valE  <= M_valE;
      W_valM  <= m_valM;
      W_dstE  <= M_dstE;
      W_dstM  <= M_dstM;
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: stimulus queues per-cycle expectations, a monitor pops and compares.
module tb_memory_stage;
  localparam logic [3:0] AOK = 4'b1000, HLT = 4'b0100, ADR = 4'b0010, NF = 4'hF;
  localparam logic [63:0] D1 = 64'h1122334455667788;
  localparam logic [63:0] D2 = 64'hCAFEF00DDEADBEEF;
  localparam logic [63:0] D3 = 64'h0123456789ABCDEF;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [0:3]  M_stat = 4'b1000;
  logic [3:0]  M_icode = 4'h1, M_dstE = 4'hF, M_dstM = 4'hF;
  logic        M_cnd = 1'b0, W_stall = 1'b0, W_bubble = 1'b0;
  logic [63:0] M_valE = '0, M_valA = '0;
  logic [0:3]  m_stat, W_stat;
  logic [63:0] m_valM, W_valE, W_valM;
  logic [3:0]  W_icode, W_dstE, W_dstM;

  memory_stage #(.MEM_BYTES(1024)) dut (
    .clk(clk), .rst_n(rst_n), .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .W_stall(W_stall), .W_bubble(W_bubble), .m_stat(m_stat), .m_valM(m_valM),
    .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          cm, cw;
    logic [3:0]  ms;
    logic [63:0] mv;
    logic [3:0]  ws, wi, wde, wdm;
    logic [63:0] we, wm;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   checks = 0, failures = 0;

  task automatic cyc(input logic [3:0] st, ic, input logic [63:0] ve, va,
                     input logic [3:0] de, dm, input bit stl = 0, bub = 0);
    @(negedge clk); #1;
    M_stat = st; M_icode = ic; M_valE = ve; M_valA = va; M_dstE = de; M_dstM = dm;
    W_stall = stl; W_bubble = bub; M_cnd = ic[0];
    cur.cm = 0; cur.cw = 0;
  endtask

  task automatic em(input logic [3:0] s, input logic [63:0] v);
    cur.cm = 1; cur.ms = s; cur.mv = v;
  endtask

  task automatic ew(input logic [3:0] s, ic, input logic [63:0] ve, vm, input logic [3:0] de, dm);
    cur.cw = 1; cur.ws = s; cur.wi = ic; cur.we = ve; cur.wm = vm; cur.wde = de; cur.wdm = dm;
  endtask

  task automatic ewb();
    ew(AOK, 4'h1, 64'h0, 64'h0, NF, NF);
  endtask

  task automatic push(input string nm);
    cur.name = nm;
    q.push_back(cur);
  endtask

  // Monitor: samples mid-low-phase, after stimulus for this cycle has settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.cm) begin
          checks++;
          if (m_stat !== e.ms || m_valM !== e.mv) begin
            failures++;
            $display("FAIL %s m_*: got stat=%b valM=%h, want stat=%b valM=%h",
                     e.name, m_stat, m_valM, e.ms, e.mv);
          end
        end
        if (e.cw) begin
          checks++;
          if (W_stat !== e.ws || W_icode !== e.wi || W_valE !== e.we || W_valM !== e.wm ||
              W_dstE !== e.wde || W_dstM !== e.wdm) begin
            failures++;
            $display("FAIL %s W_*: got %b/%h/%h/%h/%h/%h, want %b/%h/%h/%h/%h/%h", e.name,
                     W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM,
                     e.ws, e.wi, e.we, e.wm, e.wde, e.wdm);
          end
        end
      end
    end
  end

  initial begin
    logic [63:0] v26;
`ifdef DMEM_ALIGN_CHECK_EN
    v26 = D1;
`else
    v26 = {D3[31:0], D1[31:0]};
`endif
    // reset and store/load round trip
    cyc(AOK, 4'h1, 0, 0, NF, NF);              ewb(); push("reset_w");
    cyc(AOK, 4'h4, 64'h10, D1, NF, NF);        rst_n = 1'b1; em(AOK, 0); ewb(); push("store1");
    cyc(AOK, 4'h5, 64'h10, 0, NF, 4'h3);       em(AOK, D1); ew(AOK, 4'h4, 64'h10, 0, NF, NF); push("load1");
    cyc(AOK, 4'h4, 64'h3F8, D2, NF, NF);       em(AOK, 0); ew(AOK, 4'h5, 64'h10, D1, NF, 4'h3); push("store_top");
    // range check
    cyc(AOK, 4'h5, 64'h3F8, 0, NF, 4'h5);      em(AOK, D2); ew(AOK, 4'h4, 64'h3F8, 0, NF, NF); push("load_top");
    cyc(AOK, 4'h5, 64'h3F9, 0, NF, 4'h6);      em(ADR, 0); ew(AOK, 4'h5, 64'h3F8, D2, NF, 4'h5); push("load_oob");
    cyc(AOK, 4'hA, 64'hFFFFFFFFFFFFFFF8, D3, 4'h4, NF); em(ADR, 0);
    ew(ADR, 4'h5, 64'h3F9, 0, NF, 4'h6); push("push_wrap");
    cyc(AOK, 4'h1, 0, 0, NF, NF, 0, 1);        em(AOK, 0);
    ew(ADR, 4'hA, 64'hFFFFFFFFFFFFFFF8, 0, 4'h4, NF); push("w_push_adr");
    cyc(AOK, 4'h5, 64'h3F8, 0, NF, 4'h5);      em(AOK, D2); ewb(); push("push_no_write");
    // store suppression
    cyc(HLT, 4'hA, 64'h10, D3, 4'h4, NF);      em(HLT, 0); ew(AOK, 4'h5, 64'h3F8, D2, NF, 4'h5); push("push_hlt");
    cyc(AOK, 4'h5, 64'h10, 0, NF, 4'h3);       em(AOK, D1); ew(HLT, 4'hA, 64'h10, 0, 4'h4, NF); push("hlt_no_write");
    cyc(AOK, 4'h5, 64'h3F9, 0, NF, NF);        em(ADR, 0); ew(AOK, 4'h5, 64'h10, D1, NF, 4'h3); push("load_oob2");
    cyc(AOK, 4'h4, 64'h10, D3, NF, NF);        em(AOK, 0); ew(ADR, 4'h5, 64'h3F9, 0, NF, NF); push("store_wadr");
    cyc(AOK, 4'h1, 0, 0, NF, NF, 0, 1);        em(AOK, 0); ew(AOK, 4'h4, 64'h10, 0, NF, NF); push("clear_w");
    cyc(AOK, 4'h5, 64'h10, 0, NF, 4'h3);       em(AOK, D1); ewb(); push("wadr_no_write");
    // W stall / bubble control
    for (int i = 0; i < 3; i++) begin
      cyc(AOK, 4'h1, 64'h77, 0, NF, NF, 1, 0); em(AOK, 0); ew(AOK, 4'h5, 64'h10, D1, NF, 4'h3); push("stall");
    end
    cyc(AOK, 4'h1, 64'h77, 0, NF, NF, 1, 1);   ew(AOK, 4'h5, 64'h10, D1, NF, 4'h3); push("stall_held");
    cyc(AOK, 4'h5, 64'h10, 0, NF, 4'h3);       em(AOK, D1); ew(AOK, 4'h5, 64'h10, D1, NF, 4'h3); push("stall_bubble");
    cyc(AOK, 4'h1, 64'h55, 0, 4'h7, NF);       ew(AOK, 4'h5, 64'h10, D1, NF, 4'h3); push("after_stall");
    cyc(AOK, 4'h1, 64'h66, 0, 4'h8, NF);       ew(AOK, 4'h1, 64'h55, 0, 4'h7, NF); push("nop_w");
    // async reset mid-cycle during an rmmovq
    cyc(AOK, 4'h4, 64'h10, D3, NF, NF);        em(AOK, 0); #1 rst_n = 1'b0; ewb(); push("async_rst");
    cyc(AOK, 4'h5, 64'h10, 0, NF, 4'h3);       rst_n = 1'b1; em(AOK, D1); ewb(); push("rst_no_write");
    cyc(AOK, 4'h1, 0, 0, NF, NF);              ew(AOK, 4'h5, 64'h10, D1, NF, 4'h3); push("resume");
    // unaligned access
`ifdef DMEM_ALIGN_CHECK_EN
    cyc(AOK, 4'h4, 64'h14, D3, NF, NF);        em(ADR, 0); ewb(); push("store_unal");
    cyc(AOK, 4'h5, 64'h10, 0, NF, 4'h3);       em(AOK, v26); ew(ADR, 4'h4, 64'h14, 0, NF, NF); push("read_around");
    cyc(AOK, 4'h5, 64'h14, 0, NF, NF);         em(ADR, 0); ew(AOK, 4'h5, 64'h10, v26, NF, 4'h3); push("load_unal");
    cyc(AOK, 4'h1, 0, 0, NF, NF);              ew(ADR, 4'h5, 64'h14, 0, NF, NF); push("w_unal");
`else
    cyc(AOK, 4'h4, 64'h14, D3, NF, NF);        em(AOK, 0); ewb(); push("store_unal");
    cyc(AOK, 4'h5, 64'h10, 0, NF, 4'h3);       em(AOK, v26); ew(AOK, 4'h4, 64'h14, 0, NF, NF); push("read_around");
    cyc(AOK, 4'h5, 64'h14, 0, NF, NF);         em(AOK, D3); ew(AOK, 4'h5, 64'h10, v26, NF, 4'h3); push("load_unal");
    cyc(AOK, 4'h1, 0, 0, NF, NF);              ew(AOK, 4'h5, 64'h14, D3, NF, NF); push("w_unal");
`endif
    // call / ret / popq address selection, opq makes no access
    cyc(AOK, 4'h8, 64'h40, 64'h1234, 4'h4, NF);  em(AOK, 0); ewb(); push("call");
    cyc(AOK, 4'h9, 64'h48, 64'h40, 4'h4, NF);    em(AOK, 64'h1234); ew(AOK, 4'h8, 64'h40, 0, 4'h4, NF); push("ret");
    cyc(AOK, 4'hB, 64'h48, 64'h40, 4'h4, 4'h6);  em(AOK, 64'h1234); ew(AOK, 4'h9, 64'h48, 64'h1234, 4'h4, NF); push("popq");
    cyc(AOK, 4'h6, 64'h3F9, 0, 4'h3, NF);        em(AOK, 0); ew(AOK, 4'hB, 64'h48, 64'h1234, 4'h4, 4'h6); push("opq");
    cyc(AOK, 4'h1, 0, 0, NF, NF);                ew(AOK, 4'h6, 64'h3F9, 0, 4'h3, NF); push("opq_w");

    repeat (2) @(negedge clk);
    #5;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
